// File: rtl/rf_scoreboard.sv
// rf_scoreboard
//   Integer register file with two write ports and two read ports. It also
//   holds the per-register busy scoreboard used by the hazard unit and a
//   handshaked debug dump engine. Register 0 always reads zero and is never
//   busy.
//
// Ports
//   clk, rst                 clock (rising edge); asynchronous active-high reset
//   ra1/ra2 -> rd1/rd2       combinational read data, bypassed from same-cycle writes
//   busy1/busy2              scoreboard state of ra1/ra2, bypassed by same-cycle writes
//   we0/wa0/wd0              write port 0
//   we1/wa1/wd1              write port 1 (wins on an address collision)
//   issue_en/issue_rd        mark issue_rd busy from the next edge
//   dump_start               pulse: stream every register out on the dump port
//   dump_valid/dump_ready    dump beat handshake
//   dump_idx/dump_data       register index and live contents of the current beat
//   dump_last                current beat is register NREG-1
//   dump_active              dump engine is streaming
//   reg_sel -> reg_data      unbypassed debug peek
module rf_scoreboard #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  localparam int AW = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   ra1,
  input  logic [AW-1:0]   ra2,
  output logic [XLEN-1:0] rd1,
  output logic [XLEN-1:0] rd2,
  output logic            busy1,
  output logic            busy2,
  input  logic            we0,
  input  logic [AW-1:0]   wa0,
  input  logic [XLEN-1:0] wd0,
  input  logic            we1,
  input  logic [AW-1:0]   wa1,
  input  logic [XLEN-1:0] wd1,
  input  logic            issue_en,
  input  logic [AW-1:0]   issue_rd,
  input  logic            dump_start,
  output logic            dump_valid,
  input  logic            dump_ready,
  output logic [AW-1:0]   dump_idx,
  output logic [XLEN-1:0] dump_data,
  output logic            dump_last,
  output logic            dump_active,
  input  logic [AW-1:0]   reg_sel,
  output logic [XLEN-1:0] reg_data
);

  typedef enum logic {IDLE, SEND} state_t;

  // Entry 0 is reset to zero and never written, so it folds to a constant.
  logic [XLEN-1:0] rf [NREG];
  logic [NREG-1:0] busy;

  state_t          state, state_nx;
  logic [AW-1:0]   idx, idx_nx;

  logic            eff0, eff1;
  logic            hit0_1, hit1_1, hit0_2, hit1_2;

  // A write to x0 is no write at all: it neither stores nor clears busy.
  assign eff0 = we0 && (wa0 != '0);
  assign eff1 = we1 && (wa1 != '0);

  assign hit1_1 = eff1 && (wa1 == ra1);
  assign hit0_1 = eff0 && (wa0 == ra1);
  assign hit1_2 = eff1 && (wa1 == ra2);
  assign hit0_2 = eff0 && (wa0 == ra2);

  // ---- register storage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      // Port 0 is dropped when port 1 targets the same register.
      if (eff0 && !(eff1 && (wa1 == wa0))) rf[wa0] <= wd0;
      if (eff1) rf[wa1] <= wd1;
    end
  end

  // ---- scoreboard ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        // A same-cycle issue names a new producer, so set beats clear.
        if (issue_en && (issue_rd == AW'(i)))
          busy[i] <= 1'b1;
        else if ((eff0 && (wa0 == AW'(i))) || (eff1 && (wa1 == AW'(i))))
          busy[i] <= 1'b0;
      end
    end
  end

  // ---- bypassed read ports ----
  always_comb begin
    rd1 = '0;
    if (ra1 != '0) begin
      if (hit1_1)      rd1 = wd1;
      else if (hit0_1) rd1 = wd0;
      else             rd1 = rf[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 != '0) begin
      if (hit1_2)      rd2 = wd1;
      else if (hit0_2) rd2 = wd0;
      else             rd2 = rf[ra2];
    end
  end

  // A writeback landing this cycle releases the consumer immediately.
  assign busy1 = (ra1 != '0) && busy[ra1] && !(hit0_1 || hit1_1);
  assign busy2 = (ra2 != '0) && busy[ra2] && !(hit0_2 || hit1_2);

  assign reg_data = (reg_sel == '0) ? '0 : rf[reg_sel];

  // ---- dump engine ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    idx_nx     = idx;
    dump_valid = 1'b0;
    case (state)
      IDLE: begin
        if (dump_start) begin
          state_nx = SEND;
          idx_nx   = '0;
        end
      end
      SEND: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (idx == AW'(NREG - 1)) begin
            state_nx = IDLE;
            idx_nx   = '0;
          end else begin
            idx_nx = idx + AW'(1);
          end
        end
      end
      default: begin
        state_nx = IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  assign dump_active = (state == SEND);
  assign dump_idx    = idx;
  assign dump_last   = (state == SEND) && (idx == AW'(NREG - 1));
  // Live, unbypassed register value: a write to dump_idx shows on the next cycle.
  assign dump_data   = ((state == SEND) && (idx != '0)) ? rf[idx] : '0;

endmodule

// File: tb/tb_rf_scoreboard.sv
module tb_rf_scoreboard;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [AW-1:0]   ra1 = '0, ra2 = '0;
  logic [XLEN-1:0] rd1, rd2;
  logic            busy1, busy2;
  logic            we0 = 1'b0, we1 = 1'b0;
  logic [AW-1:0]   wa0 = '0, wa1 = '0;
  logic [XLEN-1:0] wd0 = '0, wd1 = '0;
  logic            issue_en = 1'b0;
  logic [AW-1:0]   issue_rd = '0;
  logic            dump_start = 1'b0;
  logic            dump_valid;
  logic            dump_ready = 1'b0;
  logic [AW-1:0]   dump_idx;
  logic [XLEN-1:0] dump_data;
  logic            dump_last;
  logic            dump_active;
  logic [AW-1:0]   reg_sel = '0;
  logic [XLEN-1:0] reg_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] data;
    logic            last;
  } beat_t;
  beat_t q[$];

  rf_scoreboard #(.XLEN(XLEN), .NREG(NREG)) dut (
    .clk(clk), .rst(rst),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .busy1(busy1), .busy2(busy2),
    .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1),
    .issue_en(issue_en), .issue_rd(issue_rd),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_idx(dump_idx), .dump_data(dump_data), .dump_last(dump_last),
    .dump_active(dump_active),
    .reg_sel(reg_sel), .reg_data(reg_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams a full dump, comparing every accepted beat against the queue.
  task automatic run_dump(input bit stall);
    beat_t b;
    int cyc;
    bit pat [4];
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    q.delete();
    for (int i = 0; i < NREG; i++) begin
      b.idx  = AW'(i);
      b.data = XLEN'(i) * 32'h10;
      b.last = (i == NREG - 1);
      q.push_back(b);
    end
    dump_ready = 1'b1;
    dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    cyc = 0;
    while (q.size() > 0 && cyc < 400) begin
      dump_ready = stall ? pat[cyc % 4] : 1'b1;
      dump_start = stall && (cyc == 5);
      #1;
      chk("dump_valid_on", dump_valid, 1'b1);
      chk("dump_idx", dump_idx, q[0].idx);
      chk("dump_data", dump_data, q[0].data);
      chk("dump_last", dump_last, q[0].last);
      if (dump_valid && dump_ready) void'(q.pop_front());
      tick();
      cyc++;
    end
    dump_start = 1'b0;
    dump_ready = 1'b1;
    chk("dump_beats_left", q.size(), 0);
    if (!stall) chk("dump_cycles", cyc, NREG);
    #1;
    chk("dump_valid_after", dump_valid, 1'b0);
    chk("dump_active_after", dump_active, 1'b0);
  endtask

  initial begin
    int guard;

    // ---- reset state ----
    ra1 = 5'd5; ra2 = 5'd7; reg_sel = 5'd5;
    #2 rst = 1'b1;
    #1;
    chk("rst_dump_valid", dump_valid, 1'b0);
    chk("rst_dump_active", dump_active, 1'b0);
    chk("rst_dump_last", dump_last, 1'b0);
    chk("rst_dump_idx", dump_idx, 0);
    chk("rst_rd1", rd1, 0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_reg_data", reg_data, 0);
    @(posedge clk);
    #3 rst = 1'b0;
    tick();

    // ---- write port 0 with bypass ----
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra1 = 5'd5;
    #1;
    chk("bypass_rd1", rd1, 32'hDEADBEEF);
    chk("peek_unbypassed", reg_data, 0);
    tick();
    we0 = 1'b0;
    #1;
    chk("rf_rd1", rd1, 32'hDEADBEEF);
    chk("peek_x5", reg_data, 32'hDEADBEEF);
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'h1234; ra1 = 5'd0;
    #1;
    chk("x0_bypass", rd1, 0);
    tick();
    we0 = 1'b0;
    reg_sel = 5'd0;
    #1;
    chk("x0_read", rd1, 0);
    chk("x0_peek", reg_data, 0);

    // ---- dual-port collision and distinct writes ----
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22;
    ra2 = 5'd7;
    #1;
    chk("collide_bypass", rd2, 32'h22);
    tick();
    we0 = 1'b0; we1 = 1'b0; reg_sel = 5'd7;
    #1;
    chk("collide_rf", rd2, 32'h22);
    chk("collide_peek", reg_data, 32'h22);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'h333;
    we1 = 1'b1; wa1 = 5'd4; wd1 = 32'h444;
    ra1 = 5'd3; ra2 = 5'd4;
    #1;
    chk("dual_byp_x3", rd1, 32'h333);
    chk("dual_byp_x4", rd2, 32'h444);
    tick();
    we0 = 1'b0; we1 = 1'b0;
    #1;
    chk("dual_x3", rd1, 32'h333);
    chk("dual_x4", rd2, 32'h444);

    // ---- scoreboard ----
    issue_en = 1'b1; issue_rd = 5'd9; ra1 = 5'd9; ra2 = 5'd0;
    #1;
    chk("busy_same_cycle_issue", busy1, 1'b0);
    tick();
    issue_en = 1'b0;
    #1;
    chk("busy_set", busy1, 1'b1);
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h99;
    #1;
    chk("busy_clear_bypass", busy1, 1'b0);
    tick();
    we0 = 1'b0;
    #1;
    chk("busy_cleared", busy1, 1'b0);
    issue_en = 1'b1; issue_rd = 5'd9;
    tick();
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h98;
    #1;
    chk("busy_write_view", busy1, 1'b0);
    tick();
    issue_en = 1'b0; we0 = 1'b0;
    #1;
    chk("busy_set_wins", busy1, 1'b1);
    issue_en = 1'b1; issue_rd = 5'd0;
    tick();
    issue_en = 1'b0;
    #1;
    chk("busy_x0", busy2, 1'b0);

    // ---- preload xi = i*0x10 ----
    for (int i = 1; i < NREG; i += 2) begin
      we0 = 1'b1; wa0 = AW'(i); wd0 = XLEN'(i) * 32'h10;
      we1 = (i + 1 < NREG); wa1 = AW'(i + 1); wd1 = XLEN'(i + 1) * 32'h10;
      tick();
    end
    we0 = 1'b0; we1 = 1'b0;
    reg_sel = 5'd31;
    #1;
    chk("preload_x31", reg_data, 32'h1F0);

    // ---- dumps ----
    run_dump(1'b0);
    run_dump(1'b1);

    // ---- reset mid-dump ----
    issue_en = 1'b1; issue_rd = 5'd10;
    tick();
    issue_rd = 5'd11;
    tick();
    issue_en = 1'b0;
    ra1 = 5'd10; ra2 = 5'd11;
    #1;
    chk("pre_abort_busy1", busy1, 1'b1);
    chk("pre_abort_busy2", busy2, 1'b1);
    dump_ready = 1'b1; dump_start = 1'b1;
    tick();
    dump_start = 1'b0;
    guard = 0;
    while (!(dump_valid && dump_idx == 5'd12) && guard < 100) begin
      tick();
      guard++;
    end
    chk("abort_reach_idx12", guard < 100, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("abort_dump_valid", dump_valid, 1'b0);
    chk("abort_dump_active", dump_active, 1'b0);
    chk("abort_dump_idx", dump_idx, 0);
    chk("abort_busy1", busy1, 1'b0);
    chk("abort_busy2", busy2, 1'b0);
    for (int i = 0; i < NREG; i++) begin
      reg_sel = AW'(i); ra1 = AW'(i);
      #0.1;
      chk("abort_reg_zero", {rd1, reg_data}, 0);
    end
    #1 rst = 1'b0;
    tick();
    chk("abort_no_resume", dump_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_scoreboard.md
# rf_scoreboard

Parametrised two-write, two-read integer register file with write-to-read bypass, a per-register busy scoreboard for the pipelined processor's hazard unit, and a handshaked debug dump engine. It sits between decode (read ports, issue/busy) and writeback (two write ports: ALU/late-load), replacing the single-write register file. Register 0 is hardwired to zero and is never busy.

## Interface
- XLEN, 32, data width
- NREG, 32, number of registers (power of two, ≥4)
- AW, $clog2(NREG), address width (derived; not overridden)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ra1, ra2  in  AW  read addresses
- rd1, rd2  out  XLEN  read data (combinational, bypassed)
- busy1, busy2  out  1  scoreboard state of ra1/ra2 (combinational, bypassed)
- we0, wa0, wd0  in  1/AW/XLEN  write port 0
- we1, wa1, wd1  in  1/AW/XLEN  write port 1 (priority port)
- issue_en, issue_rd  in  1/AW  mark issue_rd busy (pending write)
- dump_start  in  1  pulse: begin streaming all registers
- dump_valid  out  1  dump beat valid
- dump_ready  in  1  consumer accepts beat
- dump_idx  out  AW  register index of current beat
- dump_data  out  XLEN  contents of register dump_idx
- dump_last  out  1  current beat is register NREG-1
- dump_active  out  1  dump engine not IDLE
- reg_sel, reg_data  in AW / out XLEN  board debug peek (combinational, unbypassed)

## Operation
- Storage: rf[1..NREG-1]; rf[0] not stored, reads return 0.
- Writes on rising clk: port wN effective when weN=1 and waN≠0. Same address on both ports: wd1 written, wd0 dropped.
- Read bypass: rdK = 0 if raK=0; else wd1 if effective we1 and wa1=raK; else wd0 if effective we0 and wa0=raK; else rf[raK]. reg_data is never bypassed.
- Scoreboard busy[1..NREG-1], busy[0] constant 0.
  - Set: issue_en=1 and issue_rd≠0 → busy[issue_rd]←1 next edge.
  - Clear: effective write to address a → busy[a]←0, unless issue to a in same cycle (set wins: new producer).
  - busyK = busy[raK] & ~(effective write to raK this cycle); 0 when raK=0. Same-cycle issue to raK does not affect busyK until next cycle.
- Dump FSM, states IDLE, SEND:
  - IDLE: dump_valid=0. dump_start=1 → SEND, dump_idx←0.
  - SEND: dump_valid=1, dump_data = rf[dump_idx] (unbypassed, live value at that cycle; idx 0 → 0). dump_last = (dump_idx=NREG-1).
  - Beat accepted when dump_valid & dump_ready. Accepted, not last → dump_idx+1. Accepted and last → IDLE, dump_idx←0.
  - dump_valid, dump_idx, dump_data held stable while dump_ready=0 unless a write to dump_idx occurs (data follows register).
  - dump_start while SEND ignored. Register writes and issues continue normally during a dump.
- dump_active = (state=SEND).

## Timing
- Reset (async, immediate): rf[1..]=0, busy all 0, state IDLE, dump_idx=0; hence dump_valid=0, dump_last=0, dump_active=0, rd1/rd2/reg_data=0 (absent bypassing writes), busy1/busy2=0.
- Read latency 0 (combinational); write visible in rf from the edge after we; bypass makes it visible on rd in the write cycle.
- Scoreboard set/clear: 1 edge.
- Dump: first beat valid the cycle after dump_start edge; full dump with dump_ready tied 1 = NREG cycles; dump_valid falls the cycle after last acceptance.
- Reset mid-dump: aborts, outputs return to reset values immediately; no partial resume.

## Test plan
- Reset then write x5=0xDEADBEEF on port 0, ra1=5 same cycle → rd1=0xDEADBEEF (bypass), next cycle still 0xDEADBEEF via rf; write x0=0x1234 → rd1(ra1=0)=0.
- Both ports write x7 (wd0=0x11, wd1=0x22) → rd on x7 = 0x22 same and next cycle; distinct addresses x3/x4 both written.
- issue_rd=9 → busy1(ra1=9)=1 next cycle; we0 to x9 → busy1=0 same cycle (bypass), busy[9]=0 after edge; simultaneous issue and write to x9 → busy stays 1.
- Preload x1..x31 = index×0x10, dump_start with dump_ready=1 → 32 beats idx 0..31, data 0,0x10..0x1F0, dump_last only on idx 31, dump_active drops after.
- Dump with dump_ready toggling 1-0-0-1 → idx/data held during stalls, no beat skipped or duplicated; dump_start mid-dump ignored.
- Assert rst at idx 12 mid-dump with busy bits set → dump_valid=0, busy all 0, all registers read 0 immediately.
